mem_arbiter: RTL and testbench

- Shares the single-port synchronous data memory between two requesters: instruction fetch (IF, read-only) and load/store unit (LS, read/write).
- Arbitrates round-robin, registers the memory command and routes each response back to its owner.
- Fully pipelined: one accepted transaction per cycle, fixed 2-cycle request-to-response latency.
- Sits between the CPU front/back end and the memory on the memory's clk/enable/read/addr/data_in/data_out interface.

---
 rtl/mem_arbiter_pkg.sv | 28 ++
 rtl/mem_arbiter_rr_arb2.sv | 45 ++++
 rtl/mem_arbiter.sv | 129 ++++++++++++
 tb/tb_mem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the IF/LS data-memory arbiter:
//   - requester port identifiers (PORT_IF, PORT_LS)
//   - response tag carried alongside each in-flight transaction
//   - default implemented memory address width
// -----------------------------------------------------------------------------
package mem_arbiter_pkg;

  // Implemented memory address bits; addresses with any bit set above this
  // range are out of range and never reach the memory.
  localparam int MEM_AW = 16;

  // Requester identifiers, also used as bit indices into req/grant vectors.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

  // Tag that travels with each accepted transaction until its response.
  typedef struct packed {
    logic valid;  // slot holds a live transaction
    logic port;   // owner: PORT_IF or PORT_LS
    logic write;  // LS write (no read data returned)
    logic err;    // out-of-range address, memory was not accessed
  } tag_t;

  localparam tag_t TAG_IDLE = '0;

endpackage : mem_arbiter_pkg

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin arbiter. When both inputs request, the port named by
// the pointer wins; after an accepted grant the pointer moves to the other
// port. With no accept the pointer holds.
//
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset (pointer -> PORT_LS)
//   i_req      request vector, bit index = port id
//   i_advance  the current grant was accepted this cycle
//   o_grant    one-hot (or zero) grant vector, combinational
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  import mem_arbiter_pkg::*;

  // Port that wins the next contested cycle.
  logic r_ptr;

  always_comb begin
    o_grant = i_req;
    if (i_req == 2'b11) begin
      o_grant = (r_ptr == PORT_LS) ? 2'b10 : 2'b01;
    end
  end

  // NOTE: reset is sampled on the clock edge (synchronous), and all state
  // updates use non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= PORT_LS;
    end else if (i_advance && (o_grant != 2'b00)) begin
      // Hand priority to whichever port was not just served.
      r_ptr <= o_grant[PORT_IF] ? PORT_LS : PORT_IF;
    end
  end

endmodule : rr_arb2

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Shares one single-port synchronous data memory between instruction fetch
// (IF, read-only) and the load/store unit (LS, read/write). One transaction
// is accepted per cycle; the memory command is registered and the response
// returns to its owner exactly two cycles after acceptance.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   if_req/if_addr/if_ready         IF request handshake
//   if_rvalid/if_rdata/if_err       IF response
//   ls_req/ls_write/ls_addr/ls_wdata/ls_ready   LS request handshake
//   ls_rvalid/ls_rdata/ls_err       LS response (writes also respond)
//   mem_enable/mem_read/mem_addr/mem_wdata      registered memory command
//   mem_rdata                       memory read data, valid one cycle after
//                                   the read command is presented
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_AW = mem_arbiter_pkg::MEM_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction fetch
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  // load/store
  input  logic              ls_req,
  input  logic              ls_write,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              ls_err,
  // memory
  output logic              mem_enable,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import mem_arbiter_pkg::*;

  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_sel_ls;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_write;
  logic              w_err;
  logic              w_resp_if;
  logic              w_resp_ls;

  tag_t r_tag1;
  tag_t r_tag2;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     ({ls_req, if_req}),
    .i_advance (w_accept),
    .o_grant   (w_grant)
  );

  // Ready is a pure function of this cycle's requests and the pointer, so a
  // requester learns of acceptance in the same cycle. Held low during reset.
  assign if_ready = rst_n & w_grant[PORT_IF];
  assign ls_ready = rst_n & w_grant[PORT_LS];
  assign w_accept = if_ready | ls_ready;

  // ---------------------------------------------------------------------------
  // Selected request
  // ---------------------------------------------------------------------------
  assign w_sel_ls = ls_ready;
  assign w_addr   = w_sel_ls ? ls_addr : if_addr;
  assign w_wdata  = w_sel_ls ? ls_wdata : '0;
  assign w_write  = w_sel_ls & ls_write;
  assign w_err    = (w_addr >> MEM_AW) != '0;

  // ---------------------------------------------------------------------------
  // Issue stage and tag pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_enable <= 1'b0;
      mem_read   <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      r_tag1     <= TAG_IDLE;
      r_tag2     <= TAG_IDLE;
    end else begin
      // Out-of-range requests still occupy a slot and get an error response,
      // but never touch the memory.
      mem_enable <= w_accept & ~w_err;
      if (w_accept) begin
        mem_read  <= ~w_write;
        mem_addr  <= w_addr;
        mem_wdata <= w_wdata;
      end
      r_tag1 <= '{valid: w_accept, port: w_sel_ls, write: w_write, err: w_err};
      r_tag2 <= r_tag1;
    end
  end

  // ---------------------------------------------------------------------------
  // Response routing: tag2 lines up with the cycle mem_rdata is valid.
  // ---------------------------------------------------------------------------
  assign w_resp_if = r_tag2.valid & (r_tag2.port == PORT_IF);
  assign w_resp_ls = r_tag2.valid & (r_tag2.port == PORT_LS);

  assign if_rvalid = w_resp_if;
  assign if_err    = w_resp_if & r_tag2.err;
  assign if_rdata  = (w_resp_if & ~r_tag2.err) ? mem_rdata : '0;

  assign ls_rvalid = w_resp_ls;
  assign ls_err    = w_resp_ls & r_tag2.err;
  assign ls_rdata  = (w_resp_ls & ~r_tag2.err & ~r_tag2.write) ? mem_rdata : '0;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: behavioural single-port memory, a
// reference memory plus arbitration model, and per-port response scoreboards
// that also check the fixed two-cycle latency.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } ls_op_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_ready, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_write, ls_ready, ls_rvalid, ls_err;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        mem_enable, mem_read;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_ready   (if_ready),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_err     (if_err),
    .ls_req     (ls_req),
    .ls_write   (ls_write),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_ready   (ls_ready),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .ls_err     (ls_err),
    .mem_enable (mem_enable),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural single-port synchronous memory and its reference copy
  // ---------------------------------------------------------------------------
  logic [31:0] tb_mem  [0:65535];
  logic [31:0] ref_mem [0:65535];

  initial begin
    for (int i = 0; i < 65536; i++) begin
      tb_mem[i]  = 32'hC0DE_0000 | i;
      ref_mem[i] = 32'hC0DE_0000 | i;
    end
  end

  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_read) mem_rdata <= tb_mem[mem_addr[15:0]];
      else          tb_mem[mem_addr[15:0]] <= mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard, sampled on the falling edge
  // ---------------------------------------------------------------------------
  exp_t        exp_q [2][$];
  string       pname [2] = '{"if", "ls"};
  int          cyc   = 0;
  bit          m_ptr = 1'b1;   // 1 = LS wins next contested cycle
  bit          exp_en = 1'b0, exp_rd = 1'b1, exp_wr = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0;

  logic [1:0]  m_g, m_rv, m_er;
  logic [31:0] m_rd [2];
  logic [31:0] m_a;
  logic        m_wr, m_oor, m_ls;
  exp_t        m_e;

  always @(negedge clk) begin
    // memory command registered from the previous cycle's accept
    check("mem_enable", mem_enable, exp_en);
    if (exp_en) begin
      check("mem_read", mem_read, exp_rd);
      check("mem_addr", mem_addr, exp_addr);
      if (exp_wr) check("mem_wdata", mem_wdata, exp_wdata);
    end

    // responses
    m_rv = {ls_rvalid, if_rvalid};
    m_er = {ls_err, if_err};
    m_rd[0] = if_rdata;
    m_rd[1] = ls_rdata;
    for (int p = 0; p < 2; p++) begin
      if (m_rv[p]) begin
        if (exp_q[p].size() == 0) begin
          check({pname[p], "_unexpected_rvalid"}, 1, 0);
        end else begin
          m_e = exp_q[p].pop_front();
          check({pname[p], "_latency"}, cyc, m_e.due);
          check({pname[p], "_rdata"}, m_rd[p], m_e.data);
          check({pname[p], "_err"}, m_er[p], m_e.err);
        end
      end else if (exp_q[p].size() > 0 && exp_q[p][0].due <= cyc) begin
        check({pname[p], "_lost_rvalid"}, 0, 1);
        void'(exp_q[p].pop_front());
      end
    end

    // arbitration model
    m_g = {ls_req, if_req};
    if (m_g == 2'b11) m_g = m_ptr ? 2'b10 : 2'b01;
    if (!rst_n) begin
      check("if_ready_rst", if_ready, 0);
      check("ls_ready_rst", ls_ready, 0);
      foreach (exp_q[p]) exp_q[p].delete();
      m_ptr  = 1'b1;
      exp_en = 1'b0;
    end else begin
      check("if_ready", if_ready, m_g[0]);
      check("ls_ready", ls_ready, m_g[1]);
      if (m_g != 2'b00) begin
        m_ls  = m_g[1];
        m_a   = m_ls ? ls_addr : if_addr;
        m_wr  = m_ls & ls_write;
        m_oor = m_a[31:16] != 16'h0;
        m_e.due  = cyc + 2;
        m_e.err  = m_oor;
        m_e.data = (m_oor || m_wr) ? 32'h0 : ref_mem[m_a[15:0]];
        if (m_wr && !m_oor) ref_mem[m_a[15:0]] = ls_wdata;
        exp_q[m_ls].push_back(m_e);
        exp_en    = !m_oor;
        exp_rd    = !m_wr;
        exp_wr    = m_wr;
        exp_addr  = m_a;
        exp_wdata = ls_wdata;
        m_ptr     = !m_ls;
      end else begin
        exp_en = 1'b0;
      end
    end
    cyc++;
  end

  // ---------------------------------------------------------------------------
  // Requester drivers: hold each request until accepted
  // ---------------------------------------------------------------------------
  logic [31:0] if_todo [$];
  ls_op_t      ls_todo [$];
  int          p_if = 100, p_ls = 100;

  task automatic run(input int budget);
    int  n = 0;
    bit  if_on = 0, ls_on = 0, if_acc, ls_acc;
    while ((if_todo.size() > 0 || ls_todo.size() > 0) && n < budget) begin
      if (!if_on && if_todo.size() > 0 && $urandom_range(99) < p_if) if_on = 1;
      if (!ls_on && ls_todo.size() > 0 && $urandom_range(99) < p_ls) ls_on = 1;
      if_req   = if_on;
      if_addr  = if_on ? if_todo[0] : 32'h0;
      ls_req   = ls_on;
      ls_write = ls_on ? ls_todo[0].write : 1'b0;
      ls_addr  = ls_on ? ls_todo[0].addr  : 32'h0;
      ls_wdata = ls_on ? ls_todo[0].wdata : 32'h0;
      @(negedge clk);
      if_acc = if_req & if_ready;
      ls_acc = ls_req & ls_ready;
      @(posedge clk); #1;
      if (if_acc) begin void'(if_todo.pop_front()); if_on = 0; end
      if (ls_acc) begin void'(ls_todo.pop_front()); ls_on = 0; end
      n++;
    end
    if_req = 0;
    ls_req = 0;
    check("run_within_budget", n < budget, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    bit acc;
    rst_n = 0; if_req = 0; if_addr = 0;
    ls_req = 0; ls_write = 0; ls_addr = 0; ls_wdata = 0;

    // reset then idle
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_enable", mem_enable, 0);
    check("rst_mem_read",   mem_read,   1);
    check("rst_mem_addr",   mem_addr,   0);
    check("rst_mem_wdata",  mem_wdata,  0);
    check("rst_if_rvalid",  if_rvalid,  0);
    check("rst_ls_rvalid",  ls_rvalid,  0);
    check("rst_rdata",      {if_rdata, ls_rdata}, 0);
    check("rst_err",        {if_err, ls_err}, 0);
    rst_n = 1;
    idle(2);

    // LS write then back-to-back read of the same address
    ls_todo.push_back('{1'b1, 32'h0000_1234, 32'h0000_BEEF});
    ls_todo.push_back('{1'b0, 32'h0000_1234, 32'h0});
    run(20);
    idle(4);

    // both ports requesting continuously
    for (int i = 0; i < 8; i++) begin
      if_todo.push_back(32'h10 + i);
      ls_todo.push_back('{1'b0, 32'h20 + i, 32'h0});
    end
    run(40);
    idle(4);

    // out-of-range write, then an in-range read
    ls_todo.push_back('{1'b1, 32'h0001_0000, 32'hDEAD_0001});
    ls_todo.push_back('{1'b0, 32'h0000_0000, 32'h0});
    run(20);
    idle(4);

    // reset one cycle after an IF accept: its response must never appear
    if_req = 1; if_addr = 32'h5; acc = 0;
    for (int i = 0; i < 10 && !acc; i++) begin
      @(negedge clk);
      acc = if_ready;
      @(posedge clk); #1;
    end
    check("if_accept_before_reset", acc, 1);
    if_req = 0;
    rst_n  = 0;
    @(posedge clk); #1;
    rst_n  = 1;
    idle(5);
    if_todo.push_back(32'h30);
    ls_todo.push_back('{1'b0, 32'h40, 32'h0});
    run(20);
    idle(4);

    // random stream: 2000 transactions with idle gaps and out-of-range hits
    p_if = 60;
    p_ls = 60;
    for (int i = 0; i < 1000; i++) begin
      if_todo.push_back(($urandom_range(15) == 0) ? ($urandom | 32'h0001_0000)
                                                  : 32'($urandom_range(255)));
      ls_todo.push_back('{1'($urandom_range(1)),
                          ($urandom_range(15) == 0) ? ($urandom | 32'h0001_0000)
                                                    : 32'($urandom_range(255)),
                          $urandom});
    end
    run(20000);
    idle(6);

    check("if_queue_drained", exp_q[0].size(), 0);
    check("ls_queue_drained", exp_q[1].size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_mem_arbiter
